// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the two-requester ALU arbiter slice.
package alu_arbiter_pkg;
  localparam logic REQ0           = 1'b0;
  localparam logic REQ1           = 1'b1;
  // Seeding last_grant with REQ1 lets requester 0 win the first contention.
  localparam logic LAST_GRANT_RST = REQ1;
endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bus between the two requesters, the consumer and the arbiter.
interface alu_arbiter_if #(
  parameter int WORD_SIZE  = 32,
  parameter int FUNC_WIDTH = 5
);
  logic [1:0]                 req_valid;
  logic [1:0]                 req_ready;
  logic [1:0][WORD_SIZE-1:0]  req_in1;
  logic [1:0][WORD_SIZE-1:0]  req_in2;
  logic [1:0][FUNC_WIDTH-1:0] req_func;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic                       rsp_id;
  logic [WORD_SIZE-1:0]       rsp_data;

  modport master (
    output req_valid, req_in1, req_in2, req_func, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_in1, req_in2, req_func, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-way combinational round-robin arbiter; favours the requester that did not win last.
module rr_arbiter2
  import alu_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       grant_idx
);
  always_comb begin
    grant     = 2'b00;
    grant_idx = REQ0;
    if (enable) begin
      if (req[0] && req[1]) grant_idx = ~last_grant;
      else if (req[1])      grant_idx = REQ1;
      else                  grant_idx = REQ0;
      if (|req) grant = (grant_idx == REQ1) ? 2'b10 : 2'b01;
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters; result lands in a
// single registered response slot tagged with the issuing requester.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WORD_SIZE  = 32,
  parameter int FUNC_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_arbiter_if.slave          bus,
  output logic [WORD_SIZE-1:0]  alu_in1,
  output logic [WORD_SIZE-1:0]  alu_in2,
  output logic [FUNC_WIDTH-1:0] alu_func,
  input  logic [WORD_SIZE-1:0]  alu_out,
  output logic [CNT_WIDTH-1:0]  op_count
);
  logic                 rsp_valid_q;
  logic                 rsp_id_q;
  logic [WORD_SIZE-1:0] rsp_data_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 last_grant_q;
  logic                 accept_slot;
  logic [1:0]           gnt;
  logic                 gidx;
  logic                 fire;

  // Slot can take a new result if empty or being drained this very edge.
  assign accept_slot = !rsp_valid_q || bus.rsp_ready;

  rr_arbiter2 u_rr (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .enable     (accept_slot && !reset),
    .grant      (gnt),
    .grant_idx  (gidx)
  );

  // A grant is only issued to a valid requester, so any grant bit is a fire.
  assign fire          = |gnt;
  assign bus.req_ready = gnt;

  assign alu_in1  = fire ? bus.req_in1[gidx]  : '0;
  assign alu_in2  = fire ? bus.req_in2[gidx]  : '0;
  assign alu_func = fire ? bus.req_func[gidx] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= REQ0;
      rsp_data_q   <= '0;
      cnt_q        <= '0;
      last_grant_q <= LAST_GRANT_RST;
    end else if (fire) begin
      rsp_valid_q  <= 1'b1;
      rsp_id_q     <= gidx;
      rsp_data_q   <= alu_out;
      cnt_q        <= cnt_q + 1'b1;
      last_grant_q <= gidx;
    end else if (bus.rsp_ready) begin
      rsp_valid_q  <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign op_count      = cnt_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed vector bench for alu_arbiter with a behavioural ALU beside it.
module tb_alu_arbiter;
  localparam int W  = 32;
  localparam int FW = 5;
  localparam int CW = 4;
  localparam logic [4:0] F_ADD = 5'd0;
  localparam logic [4:0] F_SUB = 5'd1;
  localparam logic [4:0] F_AND = 5'd2;
  localparam logic [4:0] F_XOR = 5'd4;
  localparam logic [4:0] F_EQ  = 5'd9;

  logic          clk;
  logic          reset;
  logic [W-1:0]  alu_in1, alu_in2, alu_out;
  logic [FW-1:0] alu_func;
  logic [CW-1:0] op_count;
  int            total, passed;

  alu_arbiter_if #(.WORD_SIZE(W), .FUNC_WIDTH(FW)) bus ();

  alu_arbiter #(.WORD_SIZE(W), .FUNC_WIDTH(FW), .CNT_WIDTH(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .alu_in1  (alu_in1),
    .alu_in2  (alu_in2),
    .alu_func (alu_func),
    .alu_out  (alu_out),
    .op_count (op_count)
  );

  always_comb begin
    alu_out = '0;
    case (alu_func)
      F_ADD:   alu_out = alu_in1 + alu_in2;
      F_SUB:   alu_out = alu_in1 - alu_in2;
      F_AND:   alu_out = alu_in1 & alu_in2;
      F_XOR:   alu_out = alu_in1 ^ alu_in2;
      F_EQ:    alu_out = {31'd0, alu_in1 == alu_in2};
      default: alu_out = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  vld;
    logic [31:0] a0, b0;
    logic [4:0]  f0;
    logic [31:0] a1, b1;
    logic [4:0]  f1;
    logic        rdy;
    logic [1:0]  e_rdy;
    logic        e_rv, e_id;
    logic [31:0] e_data;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(logic r, logic [1:0] v, logic [31:0] a0, logic [31:0] b0,
                              logic [4:0] f0, logic [31:0] a1, logic [31:0] b1, logic [4:0] f1,
                              logic rr, logic [1:0] er, logic erv, logic eid,
                              logic [31:0] ed, logic [3:0] ec);
    vec_t t;
    t.rst = r; t.vld = v; t.a0 = a0; t.b0 = b0; t.f0 = f0;
    t.a1 = a1; t.b1 = b1; t.f1 = f1; t.rdy = rr;
    t.e_rdy = er; t.e_rv = erv; t.e_id = eid; t.e_data = ed; t.e_cnt = ec;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic apply(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [4:0] f0, input logic [31:0] a1, input logic [31:0] b1,
                       input logic [4:0] f1, input logic rr);
    bus.req_valid   = v;
    bus.req_in1[0]  = a0; bus.req_in2[0] = b0; bus.req_func[0] = f0;
    bus.req_in1[1]  = a1; bus.req_in2[1] = b1; bus.req_func[1] = f1;
    bus.rsp_ready   = rr;
  endtask

  function automatic logic [63:0] rsp_word();
    return 64'({bus.rsp_valid, bus.rsp_id, bus.rsp_data, op_count});
  endfunction

  initial begin
    total = 0; passed = 0;
    reset = 1'b1;
    apply(2'b11, 32'd3, 32'd5, F_ADD, 32'd3, 32'd5, F_ADD, 1'b0);
    #2;
    chk("reset_rsp", rsp_word(), 64'd0);
    chk("reset_ready", 64'(bus.req_ready), 64'd0);
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
    reset = 1'b0;

    vecs[0]  = mk(0, 2'b01, 3, 5, F_ADD, 0, 0, F_ADD, 1, 2'b01, 1, 0, 32'd8, 4'd1);
    vecs[1]  = mk(1, 2'b11, 3, 5, F_SUB, 3, 5, F_AND, 1, 2'b01, 1, 0, 32'hFFFFFFFE, 4'd1);
    vecs[2]  = mk(0, 2'b11, 3, 5, F_SUB, 3, 5, F_AND, 1, 2'b10, 1, 1, 32'h1, 4'd2);
    vecs[3]  = mk(0, 2'b11, 3, 5, F_SUB, 3, 5, F_AND, 1, 2'b01, 1, 0, 32'hFFFFFFFE, 4'd3);
    vecs[4]  = mk(0, 2'b11, 3, 5, F_SUB, 3, 5, F_AND, 1, 2'b10, 1, 1, 32'h1, 4'd4);
    vecs[5]  = mk(0, 2'b10, 0, 0, F_ADD, 3, 5, F_XOR, 1, 2'b10, 1, 1, 32'd6, 4'd5);
    vecs[6]  = mk(0, 2'b01, 3, 5, F_ADD, 3, 5, F_XOR, 0, 2'b00, 1, 1, 32'd6, 4'd5);
    vecs[7]  = mk(0, 2'b01, 3, 5, F_ADD, 3, 5, F_XOR, 0, 2'b00, 1, 1, 32'd6, 4'd5);
    vecs[8]  = mk(0, 2'b01, 3, 5, F_ADD, 3, 5, F_XOR, 0, 2'b00, 1, 1, 32'd6, 4'd5);
    vecs[9]  = mk(0, 2'b01, 3, 5, F_ADD, 3, 5, F_XOR, 1, 2'b01, 1, 0, 32'd8, 4'd6);
    vecs[10] = mk(0, 2'b00, 3, 5, F_ADD, 3, 5, F_XOR, 1, 2'b00, 0, 0, 32'd8, 4'd6);
    vecs[11] = mk(1, 2'b01, 3, 3, F_EQ,  0, 0, F_ADD, 1, 2'b01, 1, 0, 32'd1, 4'd1);
    vecs[12] = mk(0, 2'b01, 3, 3, F_EQ,  0, 0, F_ADD, 1, 2'b01, 1, 0, 32'd1, 4'd2);
    vecs[13] = mk(0, 2'b01, 3, 3, F_EQ,  0, 0, F_ADD, 1, 2'b01, 1, 0, 32'd1, 4'd3);
    vecs[14] = mk(0, 2'b01, 3, 3, F_EQ,  0, 0, F_ADD, 1, 2'b01, 1, 0, 32'd1, 4'd4);

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].rst) begin
        reset = 1'b1; #3; reset = 1'b0;
      end
      apply(vecs[i].vld, vecs[i].a0, vecs[i].b0, vecs[i].f0,
            vecs[i].a1, vecs[i].b1, vecs[i].f1, vecs[i].rdy);
      #1;
      chk($sformatf("v%0d_ready", i), 64'(bus.req_ready), 64'(vecs[i].e_rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d_rsp", i), rsp_word(),
          64'({vecs[i].e_rv, vecs[i].e_id, vecs[i].e_data, vecs[i].e_cnt}));
    end

    // Keep firing from count 4 until the 4-bit counter wraps.
    apply(2'b01, 32'd3, 32'd3, F_EQ, 32'd0, 32'd0, F_ADD, 1'b1);
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
    end
    chk("wrap_cnt15", 64'(op_count), 64'd15);
    @(posedge clk); #1;
    chk("wrap_cnt0", rsp_word(), 64'({1'b1, 1'b0, 32'd1, 4'd0}));

    apply(2'b10, 32'd0, 32'd0, F_ADD, 32'd7, 32'd9, F_ADD, 1'b1);
    #1;
    chk("alu_drive_req1", 64'({alu_in1, alu_in2, alu_func}) & 64'hFFFFFFFF_FFFFFFFF,
        64'({32'd7, 32'd9, F_ADD}) & 64'hFFFFFFFF_FFFFFFFF);
    chk("alu_drive_func", 64'(alu_func), 64'(F_ADD));
    @(posedge clk); #1;
    chk("req1_rsp", rsp_word(), 64'({1'b1, 1'b1, 32'd16, 4'd1}));

    apply(2'b00, 32'd3, 32'd5, F_SUB, 32'd3, 32'd5, F_XOR, 1'b1);
    #1;
    chk("alu_idle", 64'({alu_in1, alu_in2}), 64'd0);
    chk("alu_idle_func", 64'(alu_func), 64'd0);
    @(posedge clk); #1;

    // Leave requester 0 as last winner, hold a response, then reset mid-cycle.
    apply(2'b01, 32'd3, 32'd5, F_ADD, 32'd0, 32'd0, F_ADD, 1'b1);
    @(posedge clk); #1;
    chk("pre_rst_rsp", rsp_word(), 64'({1'b1, 1'b0, 32'd8, 4'd2}));
    apply(2'b11, 32'd3, 32'd5, F_ADD, 32'd3, 32'd5, F_SUB, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_rsp", rsp_word(), 64'd0);
    chk("rst_mid_ready", 64'(bus.req_ready), 64'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;
    chk("post_rst_rsp", rsp_word(), 64'({1'b1, 1'b0, 32'd8, 4'd1}));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
